// File: rtl/alu_div_unit_pkg.sv
// Shared ALU definitions for the divide unit and its neighbours.
//   - ALU select encodings driven by the ALU-control decoder
//   - divide/remainder control codes
//   - divide FSM state encodings
package alu_pkg;

  // ALU select encodings (decoder output). Operands reach the divide unit
  // only while the decoder drives SEL_DIV.
  localparam logic [2:0] SEL_ADD   = 3'b000;
  localparam logic [2:0] SEL_SUB   = 3'b001;
  localparam logic [2:0] SEL_DIV   = 3'b010;
  localparam logic [2:0] SEL_MUL   = 3'b011;
  localparam logic [2:0] SEL_LOGIC = 3'b100;
  localparam logic [2:0] SEL_SHIFT = 3'b101;

  // Divide control codes: bit0 = unsigned, bit1 = want remainder.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  // Divide FSM states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_div_unit_if.sv
// Handshake/data bundle between the ALU pipeline and the divide unit.
//   master : pipeline side (drives operands, control, flush, out_ready)
//   slave  : divide unit   (drives in_ready, out_valid, result)
interface alu_div_unit_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int ALU_CONTROL_WIDTH = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ALU_CONTROL_WIDTH-1:0] control;
  logic [DATA_WIDTH-1:0]        op_a;
  logic [DATA_WIDTH-1:0]        op_b;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        result;

  modport master (
    output in_valid, control, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, control, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_div_step.sv
// One radix-2 restoring divide iteration (combinational).
//   rem      : partial remainder (always < divisor on entry)
//   quo      : dividend bits still to consume, quotient bits shifting in
//   divisor  : magnitude of the divisor
//   rem_nx   : partial remainder after this step
//   quo_nx   : quotient/dividend register after this step
module alu_div_step #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_nx,
  output logic [DATA_WIDTH-1:0] quo_nx
);
  // Shifted remainder needs one extra bit: rem < divisor, so 2*rem+1 can
  // exceed DATA_WIDTH bits when the divisor's MSB is set.
  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem, quo[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[DATA_WIDTH]) begin
      rem_nx = diff[DATA_WIDTH-1:0];
      quo_nx = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[DATA_WIDTH-1:0];
      quo_nx = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle integer divide/remainder unit (div, divu, rem, remu).
// Radix-2 restoring iteration, one quotient bit per cycle, on operand
// magnitudes; signs are reapplied on the last iteration.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of alu_div_unit_if
//                in_valid/in_ready + control/op_a/op_b : request
//                out_valid/out_ready + result          : response
//                flush                                 : abort in-flight op
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int ALU_CONTROL_WIDTH = 2,
  parameter int CNT_WIDTH         = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_div_unit_if.slave bus
);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic                  want_rem_q, neg_q_q, neg_r_q;

  // Accept-side decode
  logic                  is_signed, sign_a, sign_b, div0, ovf;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;

  // Iteration datapath
  logic [DATA_WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;

  always_comb begin
    is_signed = ~bus.control[0];
    sign_a    = is_signed & bus.op_a[DATA_WIDTH-1];
    sign_b    = is_signed & bus.op_b[DATA_WIDTH-1];
    abs_a     = sign_a ? -bus.op_a : bus.op_a;
    abs_b     = sign_b ? -bus.op_b : bus.op_b;
    div0      = (bus.op_b == '0);
    // MIN / -1 would overflow the magnitude path; resolve it directly.
    ovf       = is_signed && (bus.op_a == MIN_VAL) && (bus.op_b == '1);
  end

  alu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  // Sign fixup on the final step's outputs (flags are 0 for unsigned ops).
  always_comb begin
    q_fix = neg_q_q ? -quo_nx : quo_nx;
    r_fix = neg_r_q ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      want_rem_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over accept and over the output handshake.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            want_rem_q <= bus.control[1];
            if (div0) begin
              result_q <= bus.control[1] ? bus.op_a : '1;
              state    <= DONE;
            end else if (ovf) begin
              result_q <= bus.control[1] ? '0 : bus.op_a;
              state    <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvsr_q  <= abs_b;
              neg_q_q <= sign_a ^ sign_b;
              neg_r_q <= sign_a;
              cnt     <= CNT_WIDTH'(DATA_WIDTH);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1)) begin
            result_q <= want_rem_q ? r_fix : q_fix;
            state    <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; in_ready reopens the cycle after.
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_unit.sv
// Self-checking bench for alu_div_unit: directed cases, randomized ops
// against a plain-arithmetic reference, backpressure, flush and reset.
module tb_alu_div_unit;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_div_unit_if #(.DATA_WIDTH(W), .ALU_CONTROL_WIDTH(2)) bus ();

  alu_div_unit #(.DATA_WIDTH(W), .ALU_CONTROL_WIDTH(2), .CNT_WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension divide semantics from plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == '0) return c[1] ? a : ONES;
    if (!c[0] && a == MINV && b == ONES) return c[1] ? '0 : a;
    case (c)
      2'b00:   return 64'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 64'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
    if (!c[0] && a == MINV && b == ONES) return 1;
    return W + 1;
  endfunction

  // Present one op at a negedge, return after the accept edge (+1).
  task automatic issue(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.control  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
  endtask

  // Full op with out_ready high: latency, result, and return to IDLE.
  task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    issue(c, a, b, tag);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat(c, a, b)));
    chk({tag, ".res"}, bus.result, model(c, a, b));
    @(posedge clk);
    #1;
    chk({tag, ".drop"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [1:0] c;
    logic [W-1:0] a, b;
    checks   = 0;
    failures = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.control  = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(DIV,  -64'sd7, 64'd2, "div_m7_2");
    run_op(REM,  -64'sd7, 64'd2, "rem_m7_2");
    run_op(DIVU, 64'd100, 64'd7, "divu_100_7");
    run_op(REMU, 64'd100, 64'd7, "remu_100_7");
    run_op(DIVU, ONES, 64'd2, "divu_max_2");
    run_op(DIVU, 64'd5, 64'd0, "divu_5_0");
    run_op(REMU, 64'd5, 64'd0, "remu_5_0");
    run_op(DIV,  MINV, ONES, "div_ovf");
    run_op(REM,  MINV, ONES, "rem_ovf");
    run_op(DIV,  64'd7, -64'sd2, "div_7_m2");
    run_op(REM,  64'd7, -64'sd2, "rem_7_m2");

    // Randomized ops
    for (int i = 0; i < 16; i++) begin
      c = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 64'($urandom_range(1, 20));
        2:       b = ONES;
        3:       begin a = MINV; b = ONES; end
        4:       b = {32'h0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      run_op(c, a, b, $sformatf("rnd%0d", i));
    end

    // Backpressure: hold out_ready low in DONE for 10 cycles
    bus.out_ready = 1'b0;
    issue(REMU, 64'd100, 64'd7, "bp");
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp.lat", 64'(lat), 64'(W + 1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp.hold_result", bus.result, 64'd2);
      chk("bp.hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp.release_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush at iteration 30
    issue(DIV, -64'sd1000, 64'd3, "fl");
    repeat (29) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("fl.out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl.in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("fl.no_result", 64'(seen), 64'd0);

    // Async reset mid-BUSY
    issue(DIVU, 64'd12345, 64'd17, "rs");
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rs.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rs.result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rs.no_result", 64'(seen), 64'd0);
    run_op(DIVU, 64'd9, 64'd3, "after_rs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
